// File: rtl/pl_fetch_pc_unit_if.sv
// Fetch-stage bundle between the PC/IF-ID unit and the rest of the core:
// redirect and hazard controls in, fetch address and Decode-stage contents out.
interface pl_fetch_pc_unit_if;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        RedirectE;
    logic        MisalignF;

    modport master (
        output PCSrcE, PCTargetE, ALUResultE, StallF, StallD, FlushD, InstrF,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectE, MisalignF
    );

    modport slave (
        input  PCSrcE, PCTargetE, ALUResultE, StallF, StallD, FlushD, InstrF,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectE, MisalignF
    );
endinterface

// File: rtl/pl_fetch_pc_unit.sv
// Fetch PC sequencer and IF/ID register for the pipelined RV32I core.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets instead of masking them.
module pl_fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic               clk,
    input logic               rst,
    pl_fetch_pc_unit_if.slave bus
);
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_dec_q, instr_dec_d;
    logic [31:0] pc_dec_q, pc_dec_d;
    logic [31:0] pc_plus4_dec_q, pc_plus4_dec_d;
    logic        valid_dec_q, valid_dec_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4_f;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;
    logic        misalign_set;
    logic        freeze_pc;
    logic        flush_dec;
    logic        unused_bits;

    assign pc_plus4_f = pcf_q + 32'd4;
    assign redirect   = (bus.PCSrcE != 2'b00);

    // The reserved code 10 falls through to the sequential address.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        target_raw = pc_plus4_f;
        case (bus.PCSrcE)
            2'b01:   target_raw = bus.PCTargetE;
            2'b11:   target_raw = {bus.ALUResultE[31:1], 1'b0};
            default: target_raw = pc_plus4_f;
        endcase
    end

`ifdef FETCH_MISALIGN_CHK_EN
    assign target       = target_raw;
    assign misalign_set = redirect && (target_raw[1:0] != 2'b00);
    assign freeze_pc    = misalign_q || misalign_set;
    assign unused_bits  = bus.ALUResultE[0];
`else
    assign target       = {target_raw[31:2], 2'b00};
    assign misalign_set = 1'b0;
    assign freeze_pc    = 1'b0;
    assign unused_bits  = ^{bus.ALUResultE[0], target_raw[1:0]};
`endif

    always_comb begin
        pcf_d = pcf_q;
        if (freeze_pc) begin
            pcf_d = pcf_q;
        end else if (redirect) begin
            pcf_d = target;
        end else if (!bus.StallF) begin
            pcf_d = pc_plus4_f;
        end
    end

    // A trapped core keeps squashing Decode every cycle until reset.
    assign flush_dec = bus.FlushD || redirect || misalign_q;

    always_comb begin
        instr_dec_d    = instr_dec_q;
        pc_dec_d       = pc_dec_q;
        pc_plus4_dec_d = pc_plus4_dec_q;
        valid_dec_d    = valid_dec_q;
        if (flush_dec) begin
            instr_dec_d    = NOP_INSTR;
            pc_dec_d       = 32'd0;
            pc_plus4_dec_d = 32'd0;
            valid_dec_d    = 1'b0;
        end else if (!bus.StallD) begin
            instr_dec_d    = bus.InstrF;
            pc_dec_d       = pcf_q;
            pc_plus4_dec_d = pc_plus4_f;
            valid_dec_d    = 1'b1;
        end
        misalign_d = misalign_q || misalign_set;
    end

    // NOTE: state flops use non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q          <= RESET_PC;
            instr_dec_q    <= NOP_INSTR;
            pc_dec_q       <= 32'd0;
            pc_plus4_dec_q <= 32'd0;
            valid_dec_q    <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            pcf_q          <= pcf_d;
            instr_dec_q    <= instr_dec_d;
            pc_dec_q       <= pc_dec_d;
            pc_plus4_dec_q <= pc_plus4_dec_d;
            valid_dec_q    <= valid_dec_d;
            misalign_q     <= misalign_d;
        end
    end

    assign bus.PCF       = pcf_q;
    assign bus.InstrD    = instr_dec_q;
    assign bus.PCD       = pc_dec_q;
    assign bus.PCPlus4D  = pc_plus4_dec_q;
    assign bus.ValidD    = valid_dec_q;
    assign bus.RedirectE = redirect;
    assign bus.MisalignF = misalign_q;
endmodule
